// File: rtl/srv_icache_pkg.sv
// srv_icache shared types: line geometry, FSM states, refill address format.
// Used by the top and the storage array.
package srv_icache_pkg;

  localparam int LINE_W = 128;
  localparam int WORDS_PER_LINE = 4;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  function automatic logic [31:0] fmt_ext_addr(
    input logic [27:0] line
  );
    return {2'b00, line, 2'b00};
  endfunction

endpackage

// File: rtl/srv_icache_array.sv
// srv_icache storage: per-set valid, tag and line flops.
// Combinational read by index, one synchronous write port.
module srv_icache_array
  import srv_icache_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 28 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output line_t            rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_data
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  line_t            data [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/srv_icache.sv
// srv_icache: direct-mapped read-only instruction cache, line refill on ext_*.
// Define SRV_ICACHE_STATS_EN to add hit_cnt_o / miss_cnt_o counters.
module srv_icache
  import srv_icache_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_vld_o,
  output logic        ext_req_o,
  output logic [31:0] ext_addr_o,
  input  logic        ext_rsp_i,
  input  line_t       ext_data_i
`ifdef SRV_ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 28 - IDX_W;
  localparam int OFF_W = $clog2(WORDS_PER_LINE);

  state_t state;
  logic [27:0] line_addr;
  logic req;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-1:0] off;

  logic rd_valid;
  logic [TAG_W-1:0] rd_tag;
  line_t rd_data;
  logic [31:0] word;

  logic hit;
  logic miss;
  logic wr_en;
  logic unused_bits;

  assign off = cpu_addr_i[3:2];
  assign idx = cpu_addr_i[4 +: IDX_W];
  assign tag = cpu_addr_i[31:4+IDX_W];
  assign unused_bits = ^cpu_addr_i[1:0];

  srv_icache_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (line_addr[IDX_W-1:0]),
    .wr_tag   (line_addr[27:IDX_W]),
    .wr_data  (ext_data_i)
  );

  assign hit  = rd_valid & (rd_tag == tag);
  assign miss = (state == IDLE) & cpu_req_i & ~hit;
  assign wr_en = (state == WAIT) & ext_rsp_i;

  // Gate with valid so never-written data flops cannot leak X.
  assign word = rd_data[{off, 5'b0} +: 32];
  assign cpu_data_o = rd_valid ? word : 32'h0;
  assign cpu_vld_o  = cpu_req_i & hit & (state == IDLE);

  assign ext_req_o  = req;
  assign ext_addr_o = fmt_ext_addr(line_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      line_addr <= '0;
      req       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req <= 1'b0;
          if (miss) begin
            line_addr <= cpu_addr_i[31:4];
            req       <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          req   <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          req <= 1'b0;
          if (ext_rsp_i) begin
            state <= IDLE;
          end
        end
        default: begin
          req   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SRV_ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (cpu_vld_o) hit_cnt <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`endif

endmodule

// File: tb/tb_srv_icache.sv
// Randomized self-checking bench for srv_icache against a set/tag model.
// Memory content is a fixed function of the line address.
module tb_srv_icache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_req = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_data;
  logic         cpu_vld;
  logic         ext_req;
  logic [31:0]  ext_addr;
  logic         ext_rsp = 1'b0;
  logic [127:0] ext_data = '0;
`ifdef SRV_ICACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] salt;

  bit          mv [16];
  logic [23:0] mt [16];
  int          exp_hits = 0;
  int          exp_miss = 0;

  always #5 clk = ~clk;

  srv_icache dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req_i  (cpu_req),
    .cpu_addr_i (cpu_addr),
    .cpu_data_o (cpu_data),
    .cpu_vld_o  (cpu_vld),
    .ext_req_o  (ext_req),
    .ext_addr_o (ext_addr),
    .ext_rsp_i  (ext_rsp),
    .ext_data_i (ext_data)
`ifdef SRV_ICACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mem_line(input logic [27:0] ln);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) begin
      l[32*k +: 32] = {ln, 2'(k), 2'b01} ^ salt;
    end
    return l;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [127:0] l;
    l = mem_line(a[31:4]);
    return l[32*a[3:2] +: 32];
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mv[a[7:4]] && (mt[a[7:4]] == a[31:8]);
  endfunction

  function automatic logic [31:0] line_ext(input logic [31:0] a);
    return {2'b00, a[31:4], 2'b00};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  // One fetch; on a miss runs the whole refill, responding dly cycles
  // after the request pulse. Returns in IDLE just after a clock edge.
  task automatic fetch(input logic [31:0] a, input int dly,
                       input bit use_alt, input logic [31:0] alt);
    logic [31:0] ea;
    cpu_req = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    chk("vld", {31'b0, cpu_vld}, {31'b0, model_hit(a)});
    if (model_hit(a)) begin
      exp_hits++;
      chk("hit_data", cpu_data, mem_word(a));
      chk("hit_noreq", {31'b0, ext_req}, 32'd0);
      tick();
      return;
    end
    exp_miss++;
    ea = line_ext(a);
    tick();
    if (use_alt) cpu_addr = alt;
    @(negedge clk);
    chk("req_pulse", {31'b0, ext_req}, 32'd1);
    chk("req_addr", ext_addr, ea);
    chk("req_vld", {31'b0, cpu_vld}, 32'd0);
    for (int i = 1; i < dly; i++) begin
      tick();
      @(negedge clk);
      chk("wait_req", {31'b0, ext_req}, 32'd0);
      chk("wait_addr", ext_addr, ea);
      chk("wait_vld", {31'b0, cpu_vld}, 32'd0);
    end
    tick();
    ext_rsp = 1'b1;
    ext_data = mem_line(a[31:4]);
    @(negedge clk);
    chk("rsp_vld", {31'b0, cpu_vld}, 32'd0);
    tick();
    ext_rsp = 1'b0;
    ext_data = '0;
    mv[a[7:4]] = 1'b1;
    mt[a[7:4]] = a[31:8];
  endtask

  task automatic chk_stats();
`ifdef SRV_ICACHE_STATS_EN
    @(negedge clk);
    chk("hit_cnt", hit_cnt, 32'(exp_hits));
    chk("miss_cnt", miss_cnt, 32'(exp_miss));
`endif
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic [23:0] tags [4];

  function automatic logic [31:0] rand_addr();
    logic [23:0] t;
    t = tags[$urandom_range(0, 3)];
    return {t, 4'($urandom_range(0, 3)), 4'($urandom)};
  endfunction

  initial begin
    salt = $urandom;
    tags[0] = 24'h0;
    tags[1] = 24'h1;
    tags[2] = 24'h2;
    tags[3] = 24'hABCDE5;
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", {31'b0, cpu_vld}, 32'd0);
    chk("rst_req", {31'b0, ext_req}, 32'd0);
    chk("rst_addr", ext_addr, 32'd0);
    chk("rst_data", cpu_data, 32'd0);
    tick();

    // Cold miss, hits on the filled line, conflict eviction.
    fetch(32'h10, 10, 1'b0, 32'h0);
    fetch(32'h10, 1, 1'b0, 32'h0);
    fetch(32'h14, 1, 1'b0, 32'h0);
    fetch(32'h18, 1, 1'b0, 32'h0);
    fetch(32'h1C, 1, 1'b0, 32'h0);
    fetch(32'h110, 4, 1'b0, 32'h0);
    fetch(32'h10, 3, 1'b0, 32'h0);
    chk_stats();
    fetch(32'h10, 1, 1'b0, 32'h0);

    // Address switch during the refill.
    fetch(32'h20, 6, 1'b1, 32'h30);
    fetch(32'h30, 2, 1'b0, 32'h0);
    fetch(32'h24, 1, 1'b0, 32'h0);

    // Response with no refill outstanding must not write.
    cpu_req = 1'b0;
    ext_rsp = 1'b1;
    ext_data = ~mem_line(28'h3);
    tick();
    ext_rsp = 1'b0;
    ext_data = '0;
    fetch(32'h34, 1, 1'b0, 32'h0);
    fetch(32'h28, 1, 1'b0, 32'h0);

    // Reset inside WAIT, then a stale response.
    cpu_req = 1'b1;
    cpu_addr = 32'h40;
    @(negedge clk);
    chk("pre_rst_vld", {31'b0, cpu_vld}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("in_rst_req", {31'b0, ext_req}, 32'd0);
    tick();
    rst = 1'b0;
    model_clear();
    ext_rsp = 1'b1;
    ext_data = mem_line(28'h4);
    tick();
    ext_rsp = 1'b0;
    ext_data = '0;
    @(negedge clk);
    chk("post_rst_req", {31'b0, ext_req}, 32'd0);
    chk("post_rst_addr", ext_addr, 32'd0);
    tick();
    fetch(32'h40, 5, 1'b0, 32'h0);
    fetch(32'h10, 2, 1'b0, 32'h0);
    fetch(32'h44, 1, 1'b0, 32'h0);
    chk_stats();

    // Randomized traffic over a small, conflicting address pool.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        cpu_req = 1'b0;
        cpu_addr = rand_addr();
        @(negedge clk);
        chk("idle_vld", {31'b0, cpu_vld}, 32'd0);
        chk("idle_req", {31'b0, ext_req}, 32'd0);
        tick();
      end
      ra = rand_addr();
      rb = rand_addr();
      fetch(ra, $urandom_range(1, 12), ($urandom_range(0, 3) == 0), rb);
    end
    chk_stats();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/srv_icache.md
Name: srv_icache

Overview:
- Direct-mapped instruction cache.
- Sits between the schoolRISCV core fetch port and the line-refill memory on the ext_* interface.
- Acts as the initiator of that interface. On a miss it pulses a line request, waits for the response pulse, and captures the 128-bit line.
- Serves hits combinationally from flop storage.

Parameters:
- SETS, 16, number of cache lines; power of two, at least 2.
- IDX_W, $clog2(SETS), index width; derived, do not override.
- TAG_W, 28-IDX_W, tag width; derived (byte address bits [31:4+IDX_W]).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cpu_req_i  in  1  fetch request valid
- cpu_addr_i  in  32  fetch byte address; bits [1:0] ignored
- cpu_data_o  out  32  instruction word; valid when cpu_vld_o=1
- cpu_vld_o  out  1  hit; fetch completes this cycle
- ext_req_o  out  1  one-cycle line request pulse
- ext_addr_o  out  32  line-aligned word address: {2'b0, line_addr_ff[31:4], 2'b00}
- ext_rsp_i  in  1  one-cycle response pulse; ext_data_i valid in the same cycle
- ext_data_i  in  128  line data; word k = bits [32k+31:32k]

Behaviour:
- Address split:
  - word offset = cpu_addr_i[3:2]
  - index = cpu_addr_i[4 +: IDX_W]
  - tag = cpu_addr_i[31:4+IDX_W]
- Storage per set: valid bit, TAG_W tag, 128-bit data.
- hit = valid[idx] & (tag_arr[idx] == tag).
- cpu_vld_o = cpu_req_i & hit & (state == IDLE). Purely combinational from cpu_addr_i and the arrays.
- cpu_data_o = data_arr[idx][32*offset +: 32]. It is don't-care when cpu_vld_o=0 but must be X-free after reset: data arrays are not reset, so a mux keeps the output 0 unless valid.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: cpu_req_i & ~hit → latch line_addr_ff = cpu_addr_i[31:4], go to REQ.
  - REQ: ext_req_o=1 for exactly this one cycle, then go to WAIT.
  - WAIT: hold until ext_rsp_i=1. In that cycle write data, tag and valid for the latched line, then go to IDLE.
- ext_req_o is registered (decoded from state REQ). It is never asserted two cycles in a row.
- ext_addr_o is driven from line_addr_ff in all states and is stable from REQ through WAIT.
- Latency:
  - Hit: 0 cycles.
  - Miss: cpu_vld_o rises the cycle after ext_rsp_i.
  - With a MEM_DELAY=10 responder, cpu_vld_o rises 12 cycles after the first miss cycle.
- cpu_addr_i changes during REQ/WAIT: the refill completes for the latched line regardless. The new address is looked up in IDLE and may miss again.
- cpu_req_i dropping during a refill: the refill still completes and installs the line.
- ext_rsp_i in IDLE or REQ: ignored, with no array write.
- Fill of a set that already holds another tag: overwrite (eviction) with no writeback, because the cache is read-only.
- Reset:
  - state=IDLE, all valid=0, line_addr_ff=0, ext_req_o=0, cpu_vld_o=0.
  - Reset during WAIT abandons the refill. A late ext_rsp_i is ignored.
  - The system resets the responder on the same reset.
- No flush or invalidate port.

Optional Feature:
- SRV_ICACHE_STATS_EN defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - hit_cnt_o increments on every cpu_vld_o cycle.
  - miss_cnt_o increments on every IDLE→REQ transition.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package srv_icache_pkg holds:
  - LINE_W=128, WORDS_PER_LINE=4
  - typedef line_t (logic[127:0])
  - enum state_t {IDLE, REQ, WAIT}
  - helper function for ext_addr formatting
- Sub-module srv_icache_array:
  - valid, tag and data flops
  - combinational read by index, single synchronous write port
  - clear of the valid bits on rst

Test Plan:
- Cold miss:
  - Stimulus: after reset, cpu_req_i=1, addr 0x0000_0010.
  - Required: cpu_vld_o=0; ext_req_o pulses 1 cycle with ext_addr_o=0x0000_0004; responder returns rsp with data {W3,W2,W1,W0} 10 cycles later; next cycle cpu_vld_o=1 and cpu_data_o=W0.
- Hits on the filled line:
  - Stimulus: addrs 0x14, 0x18, 0x1C on consecutive cycles.
  - Required: cpu_vld_o=1 each cycle with W1, W2, W3; no ext_req_o.
- Conflict eviction:
  - Stimulus: SETS=16, fetch 0x10 then 0x110 (same index 1, different tag).
  - Required: second fetch misses with ext_addr_o=0x44; after fill, 0x10 misses again.
- Address change in WAIT:
  - Stimulus: miss on 0x20, switch cpu_addr_i to 0x30 during WAIT.
  - Required: fill still installs line 0x20 (ext_addr_o stays 0x8); 0x30 then misses with ext_addr_o=0xC.
- Reset mid-refill:
  - Stimulus: assert rst in WAIT, then deliver a stale ext_rsp_i.
  - Required: no array write, all lookups miss, ext_req_o=0 until the next miss.
- Stats (SRV_ICACHE_STATS_EN):
  - Stimulus: the first three scenarios.
  - Required: miss_cnt_o=3, hit_cnt_o=4 (three hits plus the post-fill completion).
